// File: rtl/core_arf_dump_pkg.sv
// Shared widths and dump-FSM state encoding for the register-file dump engine.
package core_arf_dump_pkg;

    localparam int unsigned ARF_AW = 4;
    localparam int unsigned ARF_DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } dump_state_e;

endpackage

// File: rtl/core_arf_r.sv
// Combinational read port into the architectural register file.
interface core_arf_r #(
    parameter int unsigned AW = core_arf_dump_pkg::ARF_AW,
    parameter int unsigned DW = core_arf_dump_pkg::ARF_DW
);

    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    modport master (output addr, input data);
    modport slave  (input addr, output data);

endinterface

// File: rtl/core_arf_dump.sv
// Streams a contiguous (possibly wrapping) range of architectural registers out
// through a valid/ready port, one word per cycle, with abort and back-pressure.
module core_arf_dump #(
    parameter int unsigned ARF_AW = core_arf_dump_pkg::ARF_AW,
    parameter int unsigned ARF_DW = core_arf_dump_pkg::ARF_DW
) (
    input  logic              clk_i,
    input  logic              arst_i,
    core_arf_r.master         r_intf,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ARF_AW-1:0] req_first_i,
    input  logic [ARF_AW-1:0] req_last_i,
    input  logic              abort_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ARF_DW-1:0] out_data_o,
    output logic [ARF_AW-1:0] out_addr_o,
    output logic              out_last_o,
    output logic              busy_o
);

    import core_arf_dump_pkg::*;

    dump_state_e       state_q, state_d;
    logic [ARF_AW-1:0] cnt_q;
    logic [ARF_AW-1:0] end_q;
    logic              out_valid_q;
    logic [ARF_DW-1:0] out_data_q;
    logic [ARF_AW-1:0] out_addr_q;
    logic              out_last_q;

    logic accept;
    logic load;
    logic handshake;
    logic is_last;
    logic do_abort;

    assign accept    = (state_q == IDLE) && req_valid_i;
    assign handshake = out_valid_q && out_ready_i;
    assign is_last   = (cnt_q == end_q);
    assign do_abort  = (state_q != IDLE) && abort_i;
    // Abort wins over any load in the same cycle.
    assign load      = (state_q == STREAM) && !abort_i && (!out_valid_q || out_ready_i);

    assign r_intf.addr = cnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = STREAM;
            end
            STREAM: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (load && is_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_i || handshake) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
            end_q <= '0;
        end else if (accept) begin
            cnt_q <= req_first_i;
            end_q <= req_last_i;
        end else if (load && !is_last) begin
            cnt_q <= cnt_q + ARF_AW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (do_abort) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= r_intf.data;
            out_addr_q  <= cnt_q;
            out_last_q  <= is_last;
        end else if ((state_q == DRAIN) && handshake) begin
            out_valid_q <= 1'b0;
        end
    end

    // Ready is masked while reset is held so nothing looks acceptable.
    assign req_ready_o = (state_q == IDLE) && !arst_i;
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_addr_o  = out_addr_q;
    assign out_last_o  = out_last_q;

endmodule
